// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Completion-side arbiter between the functional units and the reservation
// station. Each FU pushes finished results into its own small FIFO; every
// cycle up to CDB_WIDTH FIFO heads are granted in round-robin order and the
// winners are broadcast on the registered common data bus (tags feed the RS
// tag-match CAM and the map-table ready bits). An FU whose FIFO is full is
// back-pressured through fu_stall.
//
// Optional feature macro: CDB_BYPASS_EN
//   When defined, an FU with an empty FIFO that offers a result competes in
//   the same cycle with its live input; if granted it skips the FIFO and
//   reaches the bus one cycle earlier.
//
// Ports
//   clock          : single clock, rising edge
//   reset          : asynchronous, active-low
//   flush          : synchronous squash of all buffered results
//   fu_done_valid  : [NUM_FU]         FU i presents a finished result
//   fu_done_tag    : [NUM_FU*TAG_W]   destination tag, FU i at slice i
//   fu_done_data   : [NUM_FU*DATA_W]  result value, FU i at slice i
//   fu_stall       : [NUM_FU]         FU i must hold its result
//   cdb_valid      : [CDB_WIDTH]      lane valid (CAM_en)
//   cdb_tag        : [CDB_WIDTH*TAG_W]  lane tag (CDB_in)
//   cdb_data       : [CDB_WIDTH*DATA_W] lane value
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int CDB_WIDTH = 3,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 64,
    parameter int BUF_DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_FU-1:0]           fu_done_valid,
    input  logic [NUM_FU*TAG_W-1:0]     fu_done_tag,
    input  logic [NUM_FU*DATA_W-1:0]    fu_done_data,
    output logic [NUM_FU-1:0]           fu_stall,
    output logic [CDB_WIDTH-1:0]        cdb_valid,
    output logic [CDB_WIDTH*TAG_W-1:0]  cdb_tag,
    output logic [CDB_WIDTH*DATA_W-1:0] cdb_data
);

    localparam int PTR_W = $clog2(BUF_DEPTH) + 1;
    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int MEM_D = 1 << IDX_W;
    localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int LN_W  = $clog2(CDB_WIDTH + 1);

    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [FU_W-1:0]  LAST_FU  = FU_W'(NUM_FU - 1);

    // FIFO control state
    logic [PTR_W-1:0] wptr_q  [NUM_FU];
    logic [PTR_W-1:0] wptr_d  [NUM_FU];
    logic [PTR_W-1:0] rptr_q  [NUM_FU];
    logic [PTR_W-1:0] rptr_d  [NUM_FU];
    logic [PTR_W-1:0] count_q [NUM_FU];
    logic [PTR_W-1:0] count_d [NUM_FU];

    // FIFO storage (data only, never reset)
    logic [TAG_W-1:0]  mem_tag_q  [NUM_FU][MEM_D];
    logic [DATA_W-1:0] mem_data_q [NUM_FU][MEM_D];

    logic [FU_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [CDB_WIDTH-1:0]        cdb_valid_q, cdb_valid_d;
    logic [CDB_WIDTH*TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [CDB_WIDTH*DATA_W-1:0] cdb_data_q,  cdb_data_d;

    // Candidate view of each FU
    logic [NUM_FU-1:0] cand;
    logic [TAG_W-1:0]  head_tag  [NUM_FU];
    logic [DATA_W-1:0] head_data [NUM_FU];

    // Arbitration results
    logic [NUM_FU-1:0]           grant;
    logic                        any_grant;
    logic [FU_W-1:0]             last_fu;
    logic [LN_W-1:0]             n_granted;
    logic [CDB_WIDTH-1:0]        lane_valid;
    logic [CDB_WIDTH*TAG_W-1:0]  lane_tag;
    logic [CDB_WIDTH*DATA_W-1:0] lane_data;

    logic [NUM_FU-1:0] enq;
    logic [NUM_FU-1:0] deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // ---- Stage: candidate formation (stall from registered count only) ----
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_stall[i]  = (count_q[i] == FULL_CNT);
            cand[i]      = (count_q[i] != '0);
            head_tag[i]  = mem_tag_q[i][rptr_q[i][IDX_W-1:0]];
            head_data[i] = mem_data_q[i][rptr_q[i][IDX_W-1:0]];
`ifdef CDB_BYPASS_EN
            // Empty FIFO: the live offer competes directly.
            if (count_q[i] == '0 && fu_done_valid[i]) begin
                cand[i]      = 1'b1;
                head_tag[i]  = fu_done_tag[i*TAG_W +: TAG_W];
                head_data[i] = fu_done_data[i*DATA_W +: DATA_W];
            end
`endif
        end
    end

    // ---- Stage: round-robin selection, k-th grant lands on lane k ----
    // Outer loop walks distance from rr_ptr; the inner loop turns the
    // dynamic rotation into constant indices so every select is static.
    always_comb begin
        grant      = '0;
        any_grant  = 1'b0;
        last_fu    = rr_ptr_q;
        n_granted  = '0;
        lane_valid = '0;
        lane_tag   = '0;
        lane_data  = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            for (int j = 0; j < NUM_FU; j++) begin
                if (rr_ptr_q == FU_W'(j) && cand[(j + k) % NUM_FU] &&
                    n_granted < LN_W'(CDB_WIDTH)) begin
                    grant[(j + k) % NUM_FU] = 1'b1;
                    any_grant = 1'b1;
                    last_fu   = FU_W'((j + k) % NUM_FU);
                    for (int l = 0; l < CDB_WIDTH; l++) begin
                        if (n_granted == LN_W'(l)) begin
                            lane_valid[l]                 = 1'b1;
                            lane_tag[l*TAG_W +: TAG_W]    = head_tag[(j + k) % NUM_FU];
                            lane_data[l*DATA_W +: DATA_W] = head_data[(j + k) % NUM_FU];
                        end
                    end
                    n_granted = n_granted + LN_W'(1);
                end
            end
        end
    end

    // ---- Stage: next-state (flush overrides everything) ----
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            enq[i] = fu_done_valid[i] & ~fu_stall[i] & ~flush;
            deq[i] = grant[i] & (count_q[i] != '0);
`ifdef CDB_BYPASS_EN
            // A bypassed result went straight to the bus.
            if (grant[i] && count_q[i] == '0) begin
                enq[i] = 1'b0;
            end
`endif
            wptr_d[i]  = enq[i] ? ptr_inc(wptr_q[i]) : wptr_q[i];
            rptr_d[i]  = deq[i] ? ptr_inc(rptr_q[i]) : rptr_q[i];
            count_d[i] = count_q[i];
            if (enq[i] && !deq[i]) begin
                count_d[i] = count_q[i] + PTR_W'(1);
            end else if (!enq[i] && deq[i]) begin
                count_d[i] = count_q[i] - PTR_W'(1);
            end
            if (flush) begin
                wptr_d[i]  = '0;
                rptr_d[i]  = '0;
                count_d[i] = '0;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (any_grant) begin
            rr_ptr_d = (last_fu == LAST_FU) ? '0 : last_fu + FU_W'(1);
        end

        cdb_valid_d = lane_valid;
        cdb_tag_d   = lane_tag;
        cdb_data_d  = lane_data;

        if (flush) begin
            rr_ptr_d    = '0;
            cdb_valid_d = '0;
            cdb_tag_d   = '0;
            cdb_data_d  = '0;
        end
    end

    // ---- Stage: registered control and bus ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                wptr_q[i]  <= wptr_d[i];
                rptr_q[i]  <= rptr_d[i];
                count_q[i] <= count_d[i];
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // ---- Stage: FIFO storage write ----
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (enq[i]) begin
                mem_tag_q[i][wptr_q[i][IDX_W-1:0]]  <= fu_done_tag[i*TAG_W +: TAG_W];
                mem_data_q[i][wptr_q[i][IDX_W-1:0]] <= fu_done_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Bench for cdb_arbiter with default parameters (6 FUs, 3 lanes, depth 2).
// Directed vectors cover single-FU latency/order, round-robin lane order,
// and flush; a scoreboard phase saturates all FUs and checks per-FU order,
// stall and throughput; the last phase asserts reset mid-stream.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_FU    = 6;
    localparam int CDB_WIDTH = 3;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 64;
    localparam int BUF_DEPTH = 2;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        flush = 1'b0;
    logic [NUM_FU-1:0]           fu_done_valid = '0;
    logic [NUM_FU*TAG_W-1:0]     fu_done_tag = '0;
    logic [NUM_FU*DATA_W-1:0]    fu_done_data = '0;
    logic [NUM_FU-1:0]           fu_stall;
    logic [CDB_WIDTH-1:0]        cdb_valid;
    logic [CDB_WIDTH*TAG_W-1:0]  cdb_tag;
    logic [CDB_WIDTH*DATA_W-1:0] cdb_data;

    cdb_arbiter #(
        .NUM_FU(NUM_FU), .CDB_WIDTH(CDB_WIDTH), .TAG_W(TAG_W),
        .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fu_done_valid(fu_done_valid), .fu_done_tag(fu_done_tag),
        .fu_done_data(fu_done_data), .fu_stall(fu_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        fl;
        logic [5:0]  vld;
        logic [35:0] tags;
        logic [2:0]  exp_v;
        logic [17:0] exp_tags;
        logic [5:0]  exp_stall;
    } vec_t;

    vec_t vecs[18];
    vec_t exp_q[$];

    logic [5:0] sbq [NUM_FU][$];

    function automatic logic [63:0] tag2data(input logic [5:0] t);
        return {t, 52'h0123456789ABC, ~t};
    endfunction

    function automatic logic [35:0] pack6(input logic [5:0] t0, input logic [5:0] t1,
                                          input logic [5:0] t2, input logic [5:0] t3,
                                          input logic [5:0] t4, input logic [5:0] t5);
        return {t5, t4, t3, t2, t1, t0};
    endfunction

    function automatic logic [17:0] pack3(input logic [5:0] l0, input logic [5:0] l1,
                                          input logic [5:0] l2);
        return {l2, l1, l0};
    endfunction

    function automatic logic [191:0] lanes2data(input logic [2:0] v, input logic [17:0] t);
        logic [191:0] d;
        d = '0;
        for (int l = 0; l < CDB_WIDTH; l++) begin
            if (v[l]) d[l*64 +: 64] = tag2data(t[l*6 +: 6]);
        end
        return d;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] v, input logic [35:0] t, input logic fl);
        fu_done_valid = v;
        fu_done_tag   = t;
        flush         = fl;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_done_data[i*64 +: 64] = tag2data(t[i*6 +: 6]);
        end
    endtask

    initial begin
        vec_t         e;
        logic [5:0]   cur  [NUM_FU];
        logic [2:0]   seq  [NUM_FU];
        logic         pend [NUM_FU];
        int           mcnt [NUM_FU];
        logic [5:0]   exp_stall;
        logic         saw_stall;
        int           n;
        int           fu;
        int           left;
        logic [5:0]   lt;

        // Directed vectors: one row per cycle, expectations seen that cycle.
        vecs[0]  = '{fl:1'b0, vld:6'b000100, tags:pack6(6'd0, 6'd0, 6'd5, 6'd0, 6'd0, 6'd0),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[1]  = '{fl:1'b0, vld:6'b000100, tags:pack6(6'd0, 6'd0, 6'd7, 6'd0, 6'd0, 6'd0),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[2]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b001, exp_tags:pack3(6'd5, 6'd0, 6'd0), exp_stall:'0};
        vecs[3]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b001, exp_tags:pack3(6'd7, 6'd0, 6'd0), exp_stall:'0};
        vecs[4]  = '{fl:1'b0, vld:6'b100000, tags:pack6(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd30),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[5]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[6]  = '{fl:1'b0, vld:6'b111111, tags:pack6(6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15),
                     exp_v:3'b001, exp_tags:pack3(6'd30, 6'd0, 6'd0), exp_stall:'0};
        vecs[7]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[8]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b111, exp_tags:pack3(6'd10, 6'd11, 6'd12), exp_stall:'0};
        vecs[9]  = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b111, exp_tags:pack3(6'd13, 6'd14, 6'd15), exp_stall:'0};
        vecs[10] = '{fl:1'b0, vld:6'b111111, tags:pack6(6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd45),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[11] = '{fl:1'b0, vld:6'b001000, tags:pack6(6'd0, 6'd0, 6'd0, 6'd46, 6'd0, 6'd0),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[12] = '{fl:1'b1, vld:6'b000001, tags:pack6(6'd9, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0),
                     exp_v:3'b111, exp_tags:pack3(6'd40, 6'd41, 6'd42), exp_stall:6'b001000};
        vecs[13] = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[14] = '{fl:1'b0, vld:6'b100001, tags:pack6(6'd52, 6'd0, 6'd0, 6'd0, 6'd0, 6'd53),
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[15] = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};
        vecs[16] = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b011, exp_tags:pack3(6'd52, 6'd53, 6'd0), exp_stall:'0};
        vecs[17] = '{fl:1'b0, vld:6'b000000, tags:'0,
                     exp_v:3'b000, exp_tags:'0, exp_stall:'0};

        // Reset state
        #1 reset = 1'b0;
        #2;
        chk("reset_valid", 192'(cdb_valid), 192'(0));
        chk("reset_tag",   192'(cdb_tag),   192'(0));
        chk("reset_data",  192'(cdb_data),  192'(0));
        chk("reset_stall", 192'(fu_stall),  192'(0));
        @(negedge clock);
        reset = 1'b1;

        // Directed vectors through the scoreboard queue
        for (int r = 0; r < 18; r++) begin
            @(posedge clock); #1;
            drive(vecs[r].vld, vecs[r].tags, vecs[r].fl);
            exp_q.push_back(vecs[r]);
            @(negedge clock);
            e = exp_q.pop_front();
            chk($sformatf("vec%0d_valid", r), 192'(cdb_valid), 192'(e.exp_v));
            chk($sformatf("vec%0d_tag", r),   192'(cdb_tag),   192'(e.exp_tags));
            chk($sformatf("vec%0d_data", r),  cdb_data,        lanes2data(e.exp_v, e.exp_tags));
            chk($sformatf("vec%0d_stall", r), 192'(fu_stall),  192'(e.exp_stall));
        end

        // Saturation: every FU offers every cycle for 8 cycles, then drain.
        for (int i = 0; i < NUM_FU; i++) begin
            seq[i]  = '0;
            pend[i] = 1'b0;
            mcnt[i] = 0;
            cur[i]  = '0;
        end
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(posedge clock); #1;
            if (cyc < 8) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (!pend[i]) begin
                        cur[i]  = {3'(i), seq[i]};
                        seq[i]  = seq[i] + 3'd1;
                        pend[i] = 1'b1;
                    end
                    fu_done_tag[i*6 +: 6]   = cur[i];
                    fu_done_data[i*64 +: 64] = tag2data(cur[i]);
                end
                fu_done_valid = '1;
            end else begin
                fu_done_valid = '0;
            end
            flush = 1'b0;
            @(negedge clock);
            n = 0;
            for (int l = 0; l < CDB_WIDTH; l++) begin
                lt = cdb_tag[l*6 +: 6];
                if (cdb_valid[l]) begin
                    n++;
                    fu = int'(lt[5:3]);
                    chk("sat_known", 192'(fu < NUM_FU && sbq[fu].size() > 0), 192'(1));
                    if (fu < NUM_FU && sbq[fu].size() > 0) begin
                        chk("sat_order", 192'(lt), 192'(sbq[fu][0]));
                        chk("sat_data", 192'(cdb_data[l*64 +: 64]), 192'(tag2data(sbq[fu][0])));
                        void'(sbq[fu].pop_front());
                        mcnt[fu]--;
                    end
                end else begin
                    chk("sat_idle_lane", {186'(lt), cdb_data[l*64 +: 6]}, 192'(0));
                end
            end
            if (cyc >= 2 && cyc < 8) chk($sformatf("sat_rate%0d", cyc), 192'(n), 192'(3));
            for (int i = 0; i < NUM_FU; i++) exp_stall[i] = (mcnt[i] == BUF_DEPTH);
            if (exp_stall != '0) saw_stall = 1'b1;
            chk($sformatf("sat_stall%0d", cyc), 192'(fu_stall), 192'(exp_stall));
            if (cyc < 8) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (!exp_stall[i]) begin
                        sbq[i].push_back(cur[i]);
                        mcnt[i]++;
                        pend[i] = 1'b0;
                    end
                end
            end
        end
        left = 0;
        for (int i = 0; i < NUM_FU; i++) left += sbq[i].size();
        chk("sat_drained", 192'(left), 192'(0));
        chk("sat_saw_stall", 192'(saw_stall), 192'(1));

        // Reset mid-stream with FIFOs holding data
        @(posedge clock); #1;
        drive('1, pack6(6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61), 1'b0);
        @(posedge clock); #1;
        drive('1, pack6(6'd48, 6'd49, 6'd50, 6'd51, 6'd54, 6'd55), 1'b0);
        @(posedge clock); #1;
        drive('0, '0, 1'b0);
        #1;
        chk("prerst_valid", 192'(cdb_valid), 192'(3'b111));
        reset = 1'b0;
        #1;
        chk("midrst_valid", 192'(cdb_valid), 192'(0));
        chk("midrst_tag",   192'(cdb_tag),   192'(0));
        chk("midrst_data",  cdb_data,        192'(0));
        chk("midrst_stall", 192'(fu_stall),  192'(0));
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            @(negedge clock);
            chk($sformatf("postrst%0d_valid", c), 192'(cdb_valid), 192'(0));
            chk($sformatf("postrst%0d_stall", c), 192'(fu_stall),  192'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
